// File: rtl/rv32i_alu.sv
// RV32I single-cycle ALU: combinational result/zero plus a registered trace copy.
// Define ALU_FLAGS_EN to add Negative/Carry/Overflow outputs and their registered copies.
module rv32i_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] RD1,
    input  logic [31:0] SrcB,
    input  logic [3:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic [31:0] ALUResult_q,
    output logic        Zero_q
`ifdef ALU_FLAGS_EN
    ,
    output logic        Negative,
    output logic        Carry,
    output logic        Overflow,
    output logic        Negative_q,
    output logic        Carry_q,
    output logic        Overflow_q
`endif
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    alu_op_e     op;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;

    assign op    = alu_op_e'(ALUControl);
    assign shamt = SrcB[4:0];
    assign sum   = RD1 + SrcB;
    assign diff  = RD1 - SrcB;

    // NOTE: every path of a combinational block must assign its outputs; the
    // default assignment up front is what keeps this from inferring a latch.
    always_comb begin
        ALUResult = '0;
        case (op)
            ALU_ADD:   ALUResult = sum;
            ALU_SUB:   ALUResult = diff;
            ALU_AND:   ALUResult = RD1 & SrcB;
            ALU_OR:    ALUResult = RD1 | SrcB;
            ALU_XOR:   ALUResult = RD1 ^ SrcB;
            ALU_SLL:   ALUResult = RD1 << shamt;
            ALU_SRL:   ALUResult = RD1 >> shamt;
            ALU_SRA:   ALUResult = $signed(RD1) >>> shamt;
            ALU_SLT:   ALUResult = {31'b0, $signed(RD1) < $signed(SrcB)};
            ALU_SLTU:  ALUResult = {31'b0, RD1 < SrcB};
            ALU_PASSB: ALUResult = SrcB;
            default:   ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult_q <= '0;
            Zero_q      <= 1'b0;
        end else begin
            ALUResult_q <= ALUResult;
            Zero_q      <= Zero;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [32:0] sum_ext;

    assign sum_ext  = {1'b0, RD1} + {1'b0, SrcB};
    assign Negative = ALUResult[31];

    always_comb begin
        Carry    = 1'b0;
        Overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                Carry    = sum_ext[32];
                Overflow = (RD1[31] == SrcB[31]) && (sum[31] != RD1[31]);
            end
            ALU_SUB: begin
                // Carry is "no borrow", i.e. A >= B unsigned.
                Carry    = (RD1 >= SrcB);
                Overflow = (RD1[31] != SrcB[31]) && (diff[31] != RD1[31]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Negative_q <= 1'b0;
            Carry_q    <= 1'b0;
            Overflow_q <= 1'b0;
        end else begin
            Negative_q <= Negative;
            Carry_q    <= Carry;
            Overflow_q <= Overflow;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed self-checking bench for rv32i_alu: opcodes, shift/compare corners,
// registered copy latency and asynchronous reset behaviour.
module tb_rv32i_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] RD1;
    logic [31:0] SrcB;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ALUResult_q;
    logic        Zero_q;
`ifdef ALU_FLAGS_EN
    logic        Negative, Carry, Overflow;
    logic        Negative_q, Carry_q, Overflow_q;
`endif

    int checks = 0;
    int errors = 0;

    rv32i_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RD1         (RD1),
        .SrcB        (SrcB),
        .ALUControl  (ALUControl),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .ALUResult_q (ALUResult_q),
        .Zero_q      (Zero_q)
`ifdef ALU_FLAGS_EN
        ,
        .Negative    (Negative),
        .Carry       (Carry),
        .Overflow    (Overflow),
        .Negative_q  (Negative_q),
        .Carry_q     (Carry_q),
        .Overflow_q  (Overflow_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge; combinational outputs are sampled 1 ns later.
    task automatic drive(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUControl = ctrl;
        RD1        = a;
        SrcB       = b;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        RD1        = 32'd0;
        SrcB       = 32'd0;
        ALUControl = 4'b0000;
        #2;
        check("reset_result_q", ALUResult_q, 32'd0);
        check("reset_zero_q", {31'b0, Zero_q}, 32'd0);
        check("reset_comb_zero", {31'b0, Zero}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        drive(4'b0000, 32'd100, 32'd200);
        check("add", ALUResult, 32'd300);
        check("add_zero", {31'b0, Zero}, 32'd0);
        drive(4'b0001, 32'd100, 32'd200);
        check("sub", ALUResult, 32'hFFFF_FF9C);
        drive(4'b0010, 32'd100, 32'd200);
        check("and", ALUResult, 32'd64);
        drive(4'b0011, 32'd100, 32'd200);
        check("or", ALUResult, 32'd236);
        drive(4'b0100, 32'd100, 32'd200);
        check("xor", ALUResult, 32'd172);

        drive(4'b0001, 32'h0000_1234, 32'h0000_1234);
        check("sub_eq", ALUResult, 32'd0);
        check("sub_eq_zero", {31'b0, Zero}, 32'd1);
        @(posedge clk);
        #1;
        check("sub_eq_result_q", ALUResult_q, 32'd0);
        check("sub_eq_zero_q", {31'b0, Zero_q}, 32'd1);

        drive(4'b0111, 32'h8000_0000, 32'd4);
        check("sra_neg", ALUResult, 32'hF800_0000);
        drive(4'b0110, 32'h8000_0000, 32'd4);
        check("srl", ALUResult, 32'h0800_0000);
        drive(4'b0101, 32'd1, 32'd33);
        check("sll_mask", ALUResult, 32'd2);
        drive(4'b0111, 32'h7FFF_FFF0, 32'hFFFF_FFE4);
        check("sra_pos_mask", ALUResult, 32'h07FF_FFFF);
        drive(4'b0110, 32'hF000_0000, 32'h0000_0020);
        check("srl_zero_shamt", ALUResult, 32'hF000_0000);

        drive(4'b1000, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", ALUResult, 32'd1);
        drive(4'b1001, 32'hFFFF_FFFF, 32'd1);
        check("sltu_big", ALUResult, 32'd0);
        drive(4'b1000, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_ovf", ALUResult, 32'd1);
        drive(4'b1000, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_ovf_rev", ALUResult, 32'd0);
        drive(4'b1001, 32'h8000_0000, 32'h7FFF_FFFF);
        check("sltu_msb", ALUResult, 32'd0);
        drive(4'b1010, 32'h1234_5678, 32'hABCD_0000);
        check("passb", ALUResult, 32'hABCD_0000);
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("unused_op", ALUResult, 32'd0);
        check("unused_op_zero", {31'b0, Zero}, 32'd1);
        drive(4'b1011, 32'd5, 32'd7);
        check("unused_op_1011", ALUResult, 32'd0);

        drive(4'b0000, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap", ALUResult, 32'd0);
        check("add_wrap_zero", {31'b0, Zero}, 32'd1);
`ifdef ALU_FLAGS_EN
        check("add_wrap_carry", {31'b0, Carry}, 32'd1);
        drive(4'b0000, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf_ov", {31'b0, Overflow}, 32'd1);
        check("add_ovf_neg", {31'b0, Negative}, 32'd1);
        check("add_ovf_carry", {31'b0, Carry}, 32'd0);
        @(posedge clk);
        #1;
        check("add_ovf_ov_q", {31'b0, Overflow_q}, 32'd1);
        check("add_ovf_neg_q", {31'b0, Negative_q}, 32'd1);
        drive(4'b0001, 32'd5, 32'd3);
        check("sub_nob_carry", {31'b0, Carry}, 32'd1);
        drive(4'b0001, 32'd3, 32'd5);
        check("sub_bor_carry", {31'b0, Carry}, 32'd0);
        check("sub_bor_neg", {31'b0, Negative}, 32'd1);
        @(posedge clk);
        #1;
        check("sub_bor_carry_q", {31'b0, Carry_q}, 32'd0);
        drive(4'b1000, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_flags_carry", {31'b0, Carry}, 32'd0);
        check("slt_flags_ov", {31'b0, Overflow}, 32'd0);
`endif

        // Registered copy, then an asynchronous reset between edges.
        drive(4'b0000, 32'd100, 32'd200);
        @(posedge clk);
        #1;
        check("capture_result_q", ALUResult_q, 32'd300);
        check("capture_zero_q", {31'b0, Zero_q}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result_q", ALUResult_q, 32'd0);
        check("async_rst_zero_q", {31'b0, Zero_q}, 32'd0);
        check("async_rst_comb", ALUResult, 32'd300);
        @(posedge clk);
        #1;
        check("rst_held_result_q", ALUResult_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_no_capture", ALUResult_q, 32'd0);
        @(posedge clk);
        #1;
        check("first_capture_after_rst", ALUResult_q, 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
